eth_tx_framer: RTL and testbench

Transmit-side frame sequencer for the Ethernet MAC. It accepts a byte stream from the packet source and emits a byte-wide GMII-style transmit stream: 7-byte preamble, SFD, payload, zero padding to minimum length, 4-byte FCS and inter-frame gap. It drives the external byte-serial CRC-32 engine (`eth_crc32`-style: sync `rst`, `en`, `dat`, 32-bit `crc` output updating one cycle after `en`).

---
 rtl/eth_tx_framer.sv | 154 +++++++++++++++
 tb/tb_eth_tx_framer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Transmit frame sequencer: preamble, SFD, payload, zero pad, FCS and inter-frame gap
// onto a registered byte-wide GMII-style stream, steering an external byte-serial CRC-32.
module eth_tx_framer #(
  parameter int MIN_LEN = 60,
  parameter int IFG     = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        tx_er,
  output logic        crc_rst,
  output logic        crc_en,
  output logic [7:0]  crc_dat,
  input  logic [31:0] crc,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_PAY, S_PAD, S_FCS, S_DRAIN, S_GAP
  } state_t;

  state_t      state;
  logic [10:0] cnt;
  logic [10:0] cnt_inc;
  logic [15:0] tmr;
  logic [23:0] fcs_q;
  logic        accept;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  assign cnt_inc  = sat_inc(cnt);
  assign in_ready = (state == S_PAY) || (state == S_DRAIN);
  assign accept   = in_valid && in_ready;
  assign crc_rst  = rst || (state == S_SFD);

  always_comb begin
    crc_en  = 1'b0;
    crc_dat = 8'h00;
    if (state == S_PAY && in_valid) begin
      crc_en  = 1'b1;
      crc_dat = in_data;
    end else if (state == S_PAD) begin
      crc_en  = 1'b1;
    end
  end

  // Upper three FCS bytes are held after the first one is taken straight from the engine.
  always_ff @(posedge clk) begin
    if (state == S_FCS && tmr[1:0] == 2'd0)
      fcs_q <= ~crc[31:8];
  end

  // The state runs one cycle ahead of the registered tx outputs: each state decides the
  // byte that appears on tx_data during the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tmr        <= '0;
      tx_data    <= 8'h00;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      tx_er      <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_en   <= 1'b0;
          tx_data <= 8'h00;
          if (in_valid) begin
            state   <= S_PRE;
            cnt     <= '0;
            tmr     <= '0;
            tx_en   <= 1'b1;
            tx_data <= 8'h55;
          end
        end
        S_PRE: begin
          tx_en   <= 1'b1;
          tx_data <= 8'h55;
          tmr     <= tmr + 16'd1;
          if (tmr == 16'd5) state <= S_SFD;
        end
        S_SFD: begin
          tx_en   <= 1'b1;
          tx_data <= 8'hD5;
          state   <= S_PAY;
        end
        S_PAY: begin
          tx_en <= 1'b1;
          tmr   <= '0;
          if (in_valid) begin
            tx_data <= in_data;
            cnt     <= cnt_inc;
            if (in_last)
              state <= (cnt_inc < 11'(MIN_LEN)) ? S_PAD : S_FCS;
          end else begin
            tx_data <= 8'h00;
            tx_er   <= 1'b1;
            state   <= S_DRAIN;
          end
        end
        S_PAD: begin
          tx_en   <= 1'b1;
          tx_data <= 8'h00;
          tmr     <= '0;
          cnt     <= cnt_inc;
          if (cnt_inc >= 11'(MIN_LEN)) state <= S_FCS;
        end
        S_FCS: begin
          tx_en <= 1'b1;
          tmr   <= tmr + 16'd1;
          case (tmr[1:0])
            2'd0:    tx_data <= ~crc[7:0];
            2'd1:    tx_data <= fcs_q[7:0];
            2'd2:    tx_data <= fcs_q[15:8];
            default: begin
              tx_data    <= fcs_q[23:16];
              frame_done <= 1'b1;
              state      <= S_GAP;
              tmr        <= '0;
            end
          endcase
        end
        S_DRAIN: begin
          tx_en   <= 1'b0;
          tx_data <= 8'h00;
          tmr     <= '0;
          if (accept && in_last) state <= S_GAP;
        end
        S_GAP: begin
          tx_en   <= 1'b0;
          tx_data <= 8'h00;
          tmr     <= tmr + 16'd1;
          // IFG+1 cycles here gives IFG+1 low cycles before the next preamble, counting IDLE.
          if (tmr == 16'(IFG)) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          tx_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer with a behavioural CRC-32 engine and a byte-stream
// scoreboard of expected tx bytes, run lengths and frame_done positions.
module tb_eth_tx_framer;
  localparam int MIN_LEN = 60;
  localparam int IFG     = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_er;
  logic        crc_rst;
  logic        crc_en;
  logic [7:0]  crc_dat;
  logic [31:0] crc_reg;
  logic        frame_done;

  always #5 clk = ~clk;

  eth_tx_framer #(.MIN_LEN(MIN_LEN), .IFG(IFG)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er),
    .crc_rst(crc_rst), .crc_en(crc_en), .crc_dat(crc_dat), .crc(crc_reg),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       er;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  int         len_q[$];
  logic [7:0] pay[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         run = 0;
  int         gap_run = 0;
  int         last_gap = 0;
  int         done_cnt = 0;
  logic       mon_on = 1'b0;
  exp_t       e;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Byte-serial CRC engine: sync reset, result one cycle after en.
  always @(posedge clk) begin
    if (crc_rst) crc_reg <= 32'hFFFFFFFF;
    else if (crc_en) crc_reg <= crc_byte(crc_reg, crc_dat);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic abort(input string tag);
    n_cmp++;
    n_fail++;
    $error("FAIL %s: timed out", tag);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "bench stopped");
  endtask

  always @(negedge clk) begin
    if (rst || !mon_on) begin
      run = 0;
      gap_run = 0;
    end else begin
      if (frame_done) done_cnt++;
      if (tx_en) begin
        if (gap_run > 0) last_gap = gap_run;
        gap_run = 0;
        run++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          assert (0) else begin
            n_fail++;
            $error("FAIL tx byte: observed %h with no byte expected", tx_data);
          end
        end else begin
          e = exp_q.pop_front();
          check("tx data/er/done", {tx_data, tx_er, frame_done}, e);
        end
      end else begin
        gap_run++;
        if (run > 0) begin
          if (len_q.size() == 0) check("tx_en run without expectation", run, 0);
          else check("tx_en run length", run, len_q.pop_front());
          run = 0;
        end
      end
    end
  end

  task automatic push_expected(input int ur);
    logic [31:0] c;
    int n;
    for (int i = 0; i < 7; i++) exp_q.push_back({8'h55, 1'b0, 1'b0});
    exp_q.push_back({8'hD5, 1'b0, 1'b0});
    if (ur >= 0) begin
      for (int i = 0; i < ur; i++) exp_q.push_back({pay[i], 1'b0, 1'b0});
      exp_q.push_back({8'h00, 1'b1, 1'b0});
      len_q.push_back(8 + ur + 1);
    end else begin
      c = 32'hFFFFFFFF;
      n = 0;
      foreach (pay[i]) begin
        exp_q.push_back({pay[i], 1'b0, 1'b0});
        c = crc_byte(c, pay[i]);
        n++;
      end
      while (n < MIN_LEN) begin
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        c = crc_byte(c, 8'h00);
        n++;
      end
      c = ~c;
      exp_q.push_back({c[7:0], 1'b0, 1'b0});
      exp_q.push_back({c[15:8], 1'b0, 1'b0});
      exp_q.push_back({c[23:16], 1'b0, 1'b0});
      exp_q.push_back({c[31:24], 1'b0, 1'b1});
      len_q.push_back(8 + n + 4);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is accepted.
  task automatic send(input logic [7:0] b, input logic last);
    int g;
    in_data = b;
    in_valid = 1'b1;
    in_last = last;
    g = 0;
    while (!in_ready) begin
      @(negedge clk);
      g++;
      if (g > 200) abort("send handshake");
    end
    @(negedge clk);
  endtask

  task automatic drive_frame(input int ur);
    for (int i = 0; i < pay.size(); i++) begin
      if (i == ur) begin
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
      end
      send(pay[i], i == pay.size() - 1);
    end
  endtask

  task automatic wait_quiet();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || tx_en) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) abort("frame completion");
    repeat (IFG + 4) @(negedge clk);
  endtask

  initial begin
    #500000;
    abort("global watchdog");
  end

  initial begin
    logic [7:0] s9 [9];
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    in_last = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset tx_en", tx_en, 0);
    check("reset tx_er", tx_er, 0);
    check("reset tx_data", tx_data, 0);
    check("reset frame_done", frame_done, 0);
    check("reset in_ready", in_ready, 0);
    check("reset crc_rst", crc_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle crc_rst", crc_rst, 0);
    check("idle crc_en", crc_en, 0);
    mon_on = 1'b1;
    @(negedge clk);

    // "123456789": padded to 60, first preamble byte one cycle after in_valid
    pay.delete();
    foreach (s9[i]) pay.push_back(s9[i]);
    push_expected(-1);
    in_data = pay[0];
    in_valid = 1'b1;
    @(negedge clk);
    check("first preamble tx_en", tx_en, 1);
    check("first preamble byte", tx_data, 8'h55);
    drive_frame(-1);
    check("crc after 9 bytes", crc_reg, 32'h340BC6D9);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_quiet();
    check("frame_done count after 9-byte frame", done_cnt, 1);

    // 60-byte frame: no pad
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i * 7 + 3));
    push_expected(-1);
    drive_frame(-1);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_quiet();
    check("frame_done count after 60-byte frame", done_cnt, 2);

    // Two back-to-back 64-byte frames, in_valid held high
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i * 3 + 1));
    push_expected(-1);
    drive_frame(-1);
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i) ^ 8'hA5);
    push_expected(-1);
    drive_frame(-1);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_quiet();
    check("back-to-back idle gap", last_gap, IFG + 1);
    check("frame_done count after back-to-back", done_cnt, 4);

    // Underrun at payload byte 20, remainder drained
    pay.delete();
    for (int i = 0; i < 40; i++) pay.push_back(8'(i + 8'h40));
    push_expected(20);
    drive_frame(20);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_quiet();
    check("frame_done count after underrun", done_cnt, 4);
    check("in_ready idle after drain", in_ready, 0);

    // Asynchronous reset mid-payload, then a clean frame
    mon_on = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(8'hC0 + i), 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async reset tx_en", tx_en, 0);
    check("async reset tx_er", tx_er, 0);
    check("async reset tx_data", tx_data, 0);
    check("async reset in_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    len_q.delete();
    mon_on = 1'b1;
    pay.delete();
    for (int i = 0; i < 15; i++) pay.push_back(8'(8'hF0 - i));
    push_expected(-1);
    drive_frame(-1);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_quiet();
    check("frame_done count after reset recovery", done_cnt, 5);

    // Single byte 0xAB: 59 pad bytes
    pay.delete();
    pay.push_back(8'hAB);
    push_expected(-1);
    drive_frame(-1);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_quiet();
    check("frame_done count after 1-byte frame", done_cnt, 6);
    check("scoreboard drained", exp_q.size(), 0);
    check("run lengths drained", len_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
